// File: rtl/arbitro_funcionalidades_n.sv
// Access arbiter: N users share NF numbered functions, gated by each user's access level.
// Latency 1: inputs sampled at a rising edge, all outputs registered and valid after that edge.
// No backpressure: requests are levels; grants are held HOLD_CYCLES, preemptible by higher levels.
module arbitro_funcionalidades_n #(
  parameter int N_USERS     = 4,
  parameter int LEVEL_W     = 3,
  parameter int FUNC_W      = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int IDX_W       = $clog2(N_USERS),
  localparam int NF         = (1 << FUNC_W) - 1
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [N_USERS*LEVEL_W-1:0]   UserLevel,
  input  logic [N_USERS*FUNC_W-1:0]    FuncReq,
  output logic [NF-1:0]                FuncActive,
  output logic [NF*IDX_W-1:0]          Owner,
  output logic [N_USERS-1:0]           Granted,
  output logic [N_USERS-1:0]           Waiting,
  output logic                         Denied,
  output logic [IDX_W-1:0]             DeniedUser,
  output logic [LEVEL_W-1:0]           DeniedLevel
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Per-function state; array index f-1 holds function f.
  logic [0:0]       st_q  [NF];
  logic [0:0]       st_d  [NF];
  logic [IDX_W-1:0] own_q [NF];
  logic [IDX_W-1:0] own_d [NF];
  logic [CNT_W-1:0] cnt_q [NF];
  logic [CNT_W-1:0] cnt_d [NF];
  logic [IDX_W-1:0] rr_q  [NF];
  logic [IDX_W-1:0] rr_d  [NF];

  logic [LEVEL_W-1:0] lvl [N_USERS];
  logic [FUNC_W-1:0]  fn  [N_USERS];
  logic [N_USERS-1:0] valid;

  logic [NF-1:0]        active_d;
  logic [NF*IDX_W-1:0]  owner_d;
  logic [N_USERS-1:0]   granted_d;
  logic [N_USERS-1:0]   waiting_d;
  logic                 denied_d;
  logic [IDX_W-1:0]     duser_d;
  logic [LEVEL_W-1:0]   dlevel_d;

  // Unpack user fields, classify each request as permitted or denied.
  always_comb begin
    valid    = '0;
    denied_d = 1'b0;
    duser_d  = '0;
    dlevel_d = '0;
    for (int i = 0; i < N_USERS; i++) begin
      lvl[i]   = UserLevel[i*LEVEL_W +: LEVEL_W];
      fn[i]    = FuncReq[i*FUNC_W +: FUNC_W];
      valid[i] = (fn[i] != '0) && (lvl[i] != '0) && (int'(fn[i]) <= int'(lvl[i]));
    end
    // Descending scan so the lowest denied index is the one that sticks.
    for (int i = N_USERS - 1; i >= 0; i--) begin
      if ((fn[i] != '0) && !valid[i]) begin
        denied_d = 1'b1;
        duser_d  = IDX_W'(i);
        dlevel_d = lvl[i];
      end
    end
  end

  // Per-function hold/preempt/re-arbitrate state machine and next-cycle outputs.
  always_comb begin
    logic [N_USERS-1:0] cand;
    logic [LEVEL_W-1:0] max_lvl;
    logic [LEVEL_W-1:0] own_lvl;
    logic [IDX_W-1:0]   win;
    logic               found;
    logic               own_in;
    logic               grant;
    int                 idx;
    granted_d = '0;
    owner_d   = '0;
    active_d  = '0;
    for (int f = 0; f < NF; f++) begin
      st_d[f]  = st_q[f];
      own_d[f] = own_q[f];
      cnt_d[f] = cnt_q[f];
      rr_d[f]  = rr_q[f];
      cand     = '0;
      max_lvl  = '0;
      own_lvl  = '0;
      own_in   = 1'b0;
      win      = '0;
      found    = 1'b0;
      grant    = 1'b0;
      for (int i = 0; i < N_USERS; i++) begin
        cand[i] = valid[i] && (fn[i] == FUNC_W'(f + 1));
        if (cand[i] && (lvl[i] > max_lvl)) max_lvl = lvl[i];
        if (own_q[f] == IDX_W'(i)) begin
          own_in  = cand[i];
          own_lvl = lvl[i];
        end
      end
      // Round-robin among the highest-level candidates, starting at the pointer.
      for (int k = 0; k < N_USERS; k++) begin
        idx = int'(rr_q[f]) + k;
        if (idx >= N_USERS) idx = idx - N_USERS;
        if (!found && cand[idx] && (lvl[idx] == max_lvl)) begin
          win   = IDX_W'(idx);
          found = 1'b1;
        end
      end
      if (st_q[f] == ST_IDLE) begin
        grant = |cand;
      end else if (!own_in) begin
        st_d[f] = ST_IDLE;          // owner left: release, no same-cycle re-grant
      end else if (max_lvl > own_lvl) begin
        grant = 1'b1;               // preemption by a strictly higher level
      end else if (cnt_q[f] != '0) begin
        cnt_d[f] = cnt_q[f] - CNT_W'(1);
      end else begin
        grant = 1'b1;               // hold expired: re-arbitrate
      end
      if (grant) begin
        st_d[f]  = ST_HELD;
        own_d[f] = win;
        cnt_d[f] = CNT_W'(HOLD_CYCLES - 1);
        rr_d[f]  = (win == IDX_W'(N_USERS - 1)) ? '0 : win + IDX_W'(1);
      end
      if (st_d[f] == ST_HELD) begin
        active_d[f]                 = 1'b1;
        owner_d[f*IDX_W +: IDX_W]   = own_d[f];
        for (int i = 0; i < N_USERS; i++) begin
          if (own_d[f] == IDX_W'(i)) granted_d[i] = 1'b1;
        end
      end
    end
    waiting_d = valid & ~granted_d;
  end

  // State and output registers; reset clears every grant, counter and pointer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int f = 0; f < NF; f++) begin
        st_q[f]  <= ST_IDLE;
        own_q[f] <= '0;
        cnt_q[f] <= '0;
        rr_q[f]  <= '0;
      end
      FuncActive  <= '0;
      Owner       <= '0;
      Granted     <= '0;
      Waiting     <= '0;
      Denied      <= 1'b0;
      DeniedUser  <= '0;
      DeniedLevel <= '0;
    end else begin
      for (int f = 0; f < NF; f++) begin
        st_q[f]  <= st_d[f];
        own_q[f] <= own_d[f];
        cnt_q[f] <= cnt_d[f];
        rr_q[f]  <= rr_d[f];
      end
      FuncActive  <= active_d;
      Owner       <= owner_d;
      Granted     <= granted_d;
      Waiting     <= waiting_d;
      Denied      <= denied_d;
      DeniedUser  <= duser_d;
      DeniedLevel <= dlevel_d;
    end
  end

endmodule

// File: tb/tb_arbitro_funcionalidades_n.sv
// Bench for arbitro_funcionalidades_n: N_USERS=4, HOLD_CYCLES=4 main instance plus a HOLD_CYCLES=1 instance.
// Expected output vectors are queued as stimulus is applied and popped after the next edge.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_arbitro_funcionalidades_n;

  typedef struct packed {
    logic [6:0]  fa;
    logic [13:0] own;
    logic [3:0]  gr;
    logic [3:0]  wt;
    logic        dn;
    logic [1:0]  du;
    logic [2:0]  dl;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] user_level = '0;
  logic [11:0] func_req = '0;

  logic [6:0]  fa4, fa1;
  logic [13:0] own4, own1;
  logic [3:0]  gr4, gr1, wt4, wt1;
  logic        dn4, dn1;
  logic [1:0]  du4, du1;
  logic [2:0]  dl4, dl1;

  out_t sb4 [$];
  out_t sb1 [$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  arbitro_funcionalidades_n #(.N_USERS(4), .LEVEL_W(3), .FUNC_W(3), .HOLD_CYCLES(4)) dut (
    .Clock(clk), .Reset(rst), .UserLevel(user_level), .FuncReq(func_req),
    .FuncActive(fa4), .Owner(own4), .Granted(gr4), .Waiting(wt4),
    .Denied(dn4), .DeniedUser(du4), .DeniedLevel(dl4)
  );

  arbitro_funcionalidades_n #(.N_USERS(4), .LEVEL_W(3), .FUNC_W(3), .HOLD_CYCLES(1)) dut1 (
    .Clock(clk), .Reset(rst), .UserLevel(user_level), .FuncReq(func_req),
    .FuncActive(fa1), .Owner(own1), .Granted(gr1), .Waiting(wt1),
    .Denied(dn1), .DeniedUser(du1), .DeniedLevel(dl1)
  );

  function automatic out_t obs4();
    return '{fa: fa4, own: own4, gr: gr4, wt: wt4, dn: dn4, du: du4, dl: dl4};
  endfunction

  function automatic out_t obs1();
    return '{fa: fa1, own: own1, gr: gr1, wt: wt1, dn: dn1, du: du1, dl: dl1};
  endfunction

  function automatic out_t mk(logic [6:0] fa, logic [13:0] own, logic [3:0] gr, logic [3:0] wt,
                              logic dn, logic [1:0] du, logic [2:0] dl);
    return '{fa: fa, own: own, gr: gr, wt: wt, dn: dn, du: du, dl: dl};
  endfunction

  // Owner field with user u placed in the slot of function f.
  function automatic logic [13:0] ow(int f, int u);
    logic [13:0] r;
    r = '0;
    r[(f-1)*2 +: 2] = 2'(u);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_user(int u, int l, int f);
    user_level[u*3 +: 3] = 3'(l);
    func_req[u*3 +: 3]   = 3'(f);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    user_level = '0;
    func_req = '0;
    tick();
    rst = 1'b0;
    sb4.delete();
    sb1.delete();
  endtask

  task automatic test_reset();
    out_t got, e;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      user_level = 12'($urandom);
      func_req = 12'($urandom);
      sb4.push_back('0);
      tick();
      got = obs4(); e = sb4.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL reset_hold[%0d]: got %h want %h", c, got, e); end
    end
    rst = 1'b0;
    user_level = '0; func_req = '0;
    set_user(0, 5, 1);
    sb4.push_back(mk(7'b0000001, ow(1, 0), 4'b0001, 4'b0000, 1'b0, 2'd0, 3'd0));
    tick();
    got = obs4(); e = sb4.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL reset_first_grant: got %h want %h", got, e); end
  endtask

  task automatic test_conflict();
    out_t got, e;
    reset_dut();
    set_user(0, 5, 1);
    set_user(1, 1, 1);
    sb4.push_back(mk(7'b0000001, ow(1, 0), 4'b0001, 4'b0010, 1'b0, 2'd0, 3'd0));
    tick();
    got = obs4(); e = sb4.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL conflict_grant: got %h want %h", got, e); end
    set_user(0, 5, 0);
    sb4.push_back(mk(7'b0000000, 14'd0, 4'b0000, 4'b0010, 1'b0, 2'd0, 3'd0));
    sb4.push_back(mk(7'b0000001, ow(1, 1), 4'b0010, 4'b0000, 1'b0, 2'd0, 3'd0));
    for (int c = 0; c < 2; c++) begin
      tick();
      got = obs4(); e = sb4.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL conflict_release[%0d]: got %h want %h", c, got, e); end
    end
  endtask

  task automatic test_concurrency();
    out_t got, e;
    reset_dut();
    set_user(0, 5, 2);
    set_user(1, 3, 1);
    sb4.push_back(mk(7'b0000011, ow(1, 1) | ow(2, 0), 4'b0011, 4'b0000, 1'b0, 2'd0, 3'd0));
    tick();
    got = obs4(); e = sb4.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL concurrency: got %h want %h", got, e); end
  endtask

  task automatic test_permission();
    out_t got, e;
    reset_dut();
    set_user(2, 2, 6);
    sb4.push_back(mk(7'b0000000, 14'd0, 4'b0000, 4'b0000, 1'b1, 2'd2, 3'd2));
    tick();
    got = obs4(); e = sb4.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL permission_denied: got %h want %h", got, e); end
    set_user(2, 2, 2);
    sb4.push_back(mk(7'b0000010, ow(2, 2), 4'b0100, 4'b0000, 1'b0, 2'd0, 3'd0));
    tick();
    got = obs4(); e = sb4.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL permission_fixed: got %h want %h", got, e); end
    // Two denials at once (F>L on user1, L=0 on user3): lowest index reported, grant held.
    set_user(1, 3, 4);
    set_user(3, 0, 1);
    sb4.push_back(mk(7'b0000010, ow(2, 2), 4'b0100, 4'b0000, 1'b1, 2'd1, 3'd3));
    tick();
    got = obs4(); e = sb4.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL permission_lowest: got %h want %h", got, e); end
  endtask

  task automatic test_round_robin();
    out_t got, e;
    int   o4, o1;
    reset_dut();
    set_user(0, 3, 3);
    set_user(1, 3, 3);
    for (int c = 0; c < 10; c++) begin
      o4 = (c / 4) % 2;
      o1 = c % 2;
      sb4.push_back(mk(7'b0000100, ow(3, o4), 4'(1 << o4), 4'(1 << (1 - o4)), 1'b0, 2'd0, 3'd0));
      sb1.push_back(mk(7'b0000100, ow(3, o1), 4'(1 << o1), 4'(1 << (1 - o1)), 1'b0, 2'd0, 3'd0));
      tick();
      got = obs4(); e = sb4.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL rr_hold4[%0d]: got %h want %h", c, got, e); end
      got = obs1(); e = sb1.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL rr_hold1[%0d]: got %h want %h", c, got, e); end
    end
  endtask

  task automatic test_preempt_reset();
    out_t got, e;
    reset_dut();
    set_user(1, 2, 2);
    sb4.push_back(mk(7'b0000010, ow(2, 1), 4'b0010, 4'b0000, 1'b0, 2'd0, 3'd0));
    tick();
    got = obs4(); e = sb4.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL preempt_initial: got %h want %h", got, e); end
    set_user(3, 7, 2);
    for (int c = 0; c < 5; c++) begin
      sb4.push_back(mk(7'b0000010, ow(2, 3), 4'b1000, 4'b0010, 1'b0, 2'd0, 3'd0));
      tick();
      got = obs4(); e = sb4.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL preempt_hold[%0d]: got %h want %h", c, got, e); end
    end
    rst = 1'b1;
    sb4.push_back('0);
    tick();
    got = obs4(); e = sb4.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL preempt_reset: got %h want %h", got, e); end
    rst = 1'b0;
    sb4.push_back(mk(7'b0000010, ow(2, 3), 4'b1000, 4'b0010, 1'b0, 2'd0, 3'd0));
    tick();
    got = obs4(); e = sb4.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL preempt_regrant: got %h want %h", got, e); end
  endtask

  initial begin
    #1;
    test_reset();
    test_conflict();
    test_concurrency();
    test_permission();
    test_round_robin();
    test_preempt_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arbitro_funcionalidades_n.md
# arbitro_funcionalidades_n

Parametrised, clocked access arbiter for N users sharing a set of numbered functionalities. Each cycle it checks every user's requested function against that user's access level and arbitrates per function. Distinct functions run concurrently; a shared function goes to the highest level, with round-robin among equals. Grants are held for a programmable number of cycles with preemption. It sits between the switch/button input stage and the LED-matrix/LED/7-segment output decoders.

## Interface
- N_USERS, 4, number of users (2..8)
- LEVEL_W, 3, width of a user access-level code
- FUNC_W, 3, width of a function code; NF = 2^FUNC_W − 1 functions, numbered 1..NF (0 = neutral/no request)
- HOLD_CYCLES, 8, minimum grant length in cycles (≥1)
- IDX_W, $clog2(N_USERS), user index width

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- UserLevel  in  N_USERS*LEVEL_W  level of user i at [i*LEVEL_W +: LEVEL_W]; 0 = no user
- FuncReq  in  N_USERS*FUNC_W  requested function of user i at [i*FUNC_W +: FUNC_W]; active-high, already de-inverted
- FuncActive  out  NF  bit f−1 = function f currently granted
- Owner  out  NF*IDX_W  owner index of function f at [(f−1)*IDX_W +: IDX_W]; 0 when not active
- Granted  out  N_USERS  user i owns its requested function
- Waiting  out  N_USERS  user i has a permitted request but is not owner
- Denied  out  1  some user has a non-permitted request
- DeniedUser  out  IDX_W  lowest index of a denied user; 0 if none
- DeniedLevel  out  LEVEL_W  level of DeniedUser; drives the 7-segment decoder; 0 if none

## Operation
- Valid request for user i: F = FuncReq_i ≠ 0, L = UserLevel_i ≠ 0, F ≤ L (unsigned). F ≠ 0 with L = 0 or F > L is a denied request.
- Candidate set C_f = users with a valid request for f.
- Per-function state: IDLE or HELD; registers Own_f (IDX_W), Cnt_f (counts HOLD_CYCLES−1 down to 0), RR_f (round-robin pointer, IDX_W).
- Arbitration pick(C_f): maximum level in C_f; ties resolved by the first index scanning RR_f, RR_f+1, … mod N_USERS. On every grant or re-grant, RR_f ← (winner+1) mod N_USERS.
- IDLE: C_f empty → stay IDLE. Otherwise grant pick(C_f), Cnt_f ← HOLD_CYCLES−1, go to HELD.
- HELD, evaluated in this priority order:
  1. Own_f ∉ C_f (owner dropped, changed function or lost permission) → release to IDLE. No new grant this cycle.
  2. Some candidate has a level strictly greater than the owner's → preempt: grant pick(C_f), reload Cnt_f.
  3. Cnt_f > 0 → decrement.
  4. Cnt_f = 0 → re-arbitrate: grant pick(C_f), reload Cnt_f. The owner keeps the grant only if it is the sole maximum or wins the round-robin.
- Granted_i = OR over f of (HELD_f and Own_f = i). Waiting_i = valid request and not Granted_i.
- Denied, DeniedUser and DeniedLevel are recomputed each cycle from the current inputs. They are levels, not pulses.
- HOLD_CYCLES = 1: every HELD cycle takes the Cnt_f = 0 branch, giving per-cycle round-robin among equals.

## Timing
- All outputs are registered. Inputs are sampled at rising edge t; results are visible after edge t for one full cycle, a latency of 1.
- Reset, sampled at an edge, wins over everything. After that edge:
  - all outputs are 0;
  - all functions are IDLE;
  - Cnt_f = 0 and RR_f = 0.
- Reset mid-hold drops all grants at that edge. Arbitration resumes on the first edge with Reset low.
- Release and re-grant of the same function in one cycle is impossible. After a rule-1 release, a remaining candidate is granted 1 edge later, so FuncActive bit is low for exactly one cycle.
- Simultaneous new requests on different functions are all granted on the same edge.
- A user holds at most one function, since FuncReq is a single code.
- Owner width wrap: RR_f wraps from N_USERS−1 to 0. With non-power-of-two N_USERS, indices ≥ N_USERS are never produced.

## Test plan
Unless stated otherwise, N_USERS=4 and HOLD_CYCLES=4.
- Reset held 2 cycles with random inputs → all outputs 0. Release Reset with user0 L=5 F=1 → after next edge FuncActive=0000001, Owner_1=0, Granted=0001.
- Conflict on the same function: user0 L=5 F=1, user1 L=1 F=1 → Owner_1=0, Granted=0001, Waiting=0010. User0 drops F → one cycle FuncActive=0. Next edge Owner_1=1, Granted=0010.
- Concurrency: user0 L=5 F=2, user1 L=3 F=1 → both granted on the same edge. FuncActive=0000011, Granted=0011, Waiting=0000.
- Permission: user2 L=2 F=6 → Denied=1, DeniedUser=2, DeniedLevel=2, FuncActive[5]=0, Waiting[2]=0. Change to F=2 → Denied=0 and user2 granted the next edge.
- Round-robin: user0 and user1 both L=3 F=3, held constant → Owner_3 alternates 0,0,0,0,1,1,1,1,0… Repeat with HOLD_CYCLES=1 → Owner_3 alternates every cycle.
- Preemption and reset mid-hold: user1 L=2 holds F=2 for 1 cycle; user3 L=7 asserts F=2 → next edge Owner_2=3, user1 Waiting, counter reloaded (user3 holds ≥4 cycles). Then Reset for 1 cycle → all outputs 0 at that edge. Re-grant to user3 on the first edge after Reset is released.
